stream_fifo: RTL and testbench

// Parametrised flip-flop FIFO with valid/ready handshakes on both sides,

---
 rtl/stream_fifo.sv | 93 +++++++++
 tb/tb_stream_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
// stream_fifo: flip-flop circular FIFO with valid/ready on both sides,
// first-word-fall-through head, occupancy count, level flags and flush.
module stream_fifo #(
    parameter int  WIDTH    = 8,
    parameter int  DEPTH    = 4,
    parameter int  AF_LEVEL = DEPTH - 1,
    parameter int  AE_LEVEL = 1,
    localparam int CW       = $clog2(DEPTH + 1),
    localparam int PW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             live_q, live_d;
    logic             push, pop;

    // live_q holds in_ready low until the first edge after reset release
    assign in_ready     = live_q && (count_q != CNT_FULL);
    assign out_valid    = (count_q != '0);
    assign out_data     = mem_q[rd_ptr_q];
    assign count        = count_q;
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        live_d   = 1'b1;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            live_q   <= live_d;
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed checks of stream_fifo at DEPTH 4, 3 and 8
// (reset, fill/drain, wrap with stalls, push+pop, flush, level flags).
module tb_stream_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush;
    int   total = 0;
    int   bad   = 0;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_af, a_ae;
    logic [7:0] a_in_data, a_out_data;
    logic [2:0] a_count;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_af, b_ae;
    logic [7:0] b_in_data, b_out_data;
    logic [1:0] b_count;

    logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_af, c_ae;
    logic [7:0] c_in_data, c_out_data;
    logic [3:0] c_count;

    stream_fifo #(.WIDTH(8), .DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .count(a_count),
        .almost_full(a_af), .almost_empty(a_ae)
    );

    stream_fifo #(.WIDTH(8), .DEPTH(3)) u3 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .count(b_count),
        .almost_full(b_af), .almost_empty(b_ae)
    );

    stream_fifo #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) u8 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .count(c_count),
        .almost_full(c_af), .almost_empty(c_ae)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        total++;
        if (a_count !== 3'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_state count=%0d ov=%b ir=%b exp 0/0/0",
                     a_count, a_out_valid, a_in_ready);
        end
        total++;
        if (a_ae !== 1'b1 || a_af !== 1'b0 || a_out_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_flags ae=%b af=%b data=%h exp 1/0/00",
                     a_ae, a_af, a_out_data);
        end
        tick;
        tick;
        rst = 1'b1;
        #1;
        total++;
        if (a_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge got=%b exp=0", a_in_ready);
        end
        tick;
        total++;
        if (a_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_edge got=%b exp=1", a_in_ready);
        end
    endtask

    task automatic test_reset_mid;
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'h31 + 8'(i);
            tick;
        end
        a_in_valid = 1'b0;
        total++;
        if (a_count !== 3'd3) begin
            bad++;
            $display("FAIL mid_pre_count got=%0d exp=3", a_count);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (a_count !== 3'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_async count=%0d ov=%b ir=%b exp 0/0/0",
                     a_count, a_out_valid, a_in_ready);
        end
        #1;
        rst = 1'b1;
        tick;
        total++;
        if (a_in_ready !== 1'b1 || a_count !== 3'd0) begin
            bad++;
            $display("FAIL mid_release ir=%b count=%0d exp 1/0",
                     a_in_ready, a_count);
        end
    endtask

    task automatic test_fill_drain;
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'hA1 + 8'(i);
            tick;
            total++;
            if (a_count !== 3'(i + 1)) begin
                bad++;
                $display("FAIL fill_count%0d got=%0d exp=%0d", i, a_count, i + 1);
            end
        end
        total++;
        if (a_in_ready !== 1'b0 || a_af !== 1'b1) begin
            bad++;
            $display("FAIL full_flags ir=%b af=%b exp 0/1", a_in_ready, a_af);
        end
        a_in_data = 8'hA5;
        tick;
        a_in_valid = 1'b0;
        total++;
        if (a_count !== 3'd4) begin
            bad++;
            $display("FAIL full_ignore count=%0d exp=4", a_count);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (a_out_valid !== 1'b1 || a_out_data !== 8'hA1 + 8'(i)) begin
                bad++;
                $display("FAIL drain%0d ov=%b data=%h exp 1/%h",
                         i, a_out_valid, a_out_data, 8'hA1 + 8'(i));
            end
            a_out_ready = 1'b1;
            tick;
            a_out_ready = 1'b0;
        end
        total++;
        if (a_count !== 3'd0 || a_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain_empty count=%0d ov=%b exp 0/0", a_count, a_out_valid);
        end
    endtask

    task automatic test_wrap;
        int sent = 0;
        int rcv  = 0;
        int cyc  = 0;
        while (rcv < 100 && cyc < 3000) begin
            b_in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
            b_in_data   = 8'(sent);
            b_out_ready = ($urandom_range(0, 2) != 0);
            #3;
            if (b_out_valid && b_out_ready) begin
                total++;
                if (b_out_data !== 8'(rcv)) begin
                    bad++;
                    $display("FAIL wrap_data got=%0d exp=%0d", b_out_data, rcv);
                end
                rcv++;
            end
            if (b_in_valid && b_in_ready) sent++;
            tick;
            cyc++;
            total++;
            if (b_count !== 2'(sent - rcv) || sent - rcv > 3) begin
                bad++;
                $display("FAIL wrap_count got=%0d exp=%0d", b_count, sent - rcv);
            end
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        total++;
        if (rcv != 100) begin
            bad++;
            $display("FAIL wrap_timeout got=%0d words exp=100", rcv);
        end
    endtask

    task automatic test_back_to_back;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h10;
        tick;
        a_in_data   = 8'h11;
        tick;
        a_in_data   = 8'h12;
        a_out_ready = 1'b1;
        tick;
        total++;
        if (a_count !== 3'd2 || a_out_data !== 8'h11) begin
            bad++;
            $display("FAIL pushpop count=%0d head=%h exp 2/11", a_count, a_out_data);
        end
        a_out_ready = 1'b0;
        a_in_data   = 8'h13;
        tick;
        a_in_data   = 8'h14;
        tick;
        a_in_data   = 8'h15;
        a_out_ready = 1'b1;
        tick;
        a_in_valid  = 1'b0;
        total++;
        if (a_count !== 3'd3 || a_out_data !== 8'h12) begin
            bad++;
            $display("FAIL full_pop count=%0d head=%h exp 3/12", a_count, a_out_data);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (a_out_data !== 8'h12 + 8'(i)) begin
                bad++;
                $display("FAIL b2b_drain%0d got=%h exp=%h",
                         i, a_out_data, 8'h12 + 8'(i));
            end
            tick;
        end
        a_out_ready = 1'b0;
        total++;
        if (a_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_empty ov=%b exp=0", a_out_valid);
        end
    endtask

    task automatic test_flush;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in_data = 8'h21 + 8'(i);
            tick;
        end
        a_in_data = 8'h24;
        flush     = 1'b1;
        tick;
        flush     = 1'b0;
        a_in_valid = 1'b0;
        total++;
        if (a_count !== 3'd0 || a_out_valid !== 1'b0 || a_ae !== 1'b1) begin
            bad++;
            $display("FAIL flush count=%0d ov=%b ae=%b exp 0/0/1",
                     a_count, a_out_valid, a_ae);
        end
        a_in_valid = 1'b1;
        a_in_data  = 8'h25;
        tick;
        a_in_valid = 1'b0;
        total++;
        if (a_count !== 3'd1 || a_out_data !== 8'h25) begin
            bad++;
            $display("FAIL post_flush count=%0d head=%h exp 1/25",
                     a_count, a_out_data);
        end
        a_out_ready = 1'b1;
        tick;
        a_out_ready = 1'b0;
    endtask

    task automatic test_flags;
        logic [8:0] ae_tab = 9'b000000111;
        logic [8:0] af_tab = 9'b111000000;
        c_out_ready = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            total++;
            if (c_count !== 4'(c) || c_ae !== ae_tab[c] || c_af !== af_tab[c]) begin
                bad++;
                $display("FAIL flags_up%0d count=%0d ae=%b af=%b exp %0d/%b/%b",
                         c, c_count, c_ae, c_af, c, ae_tab[c], af_tab[c]);
            end
            if (c < 8) begin
                c_in_valid = 1'b1;
                c_in_data  = 8'(c);
                tick;
                c_in_valid = 1'b0;
            end
        end
        for (int c = 7; c >= 0; c--) begin
            c_out_ready = 1'b1;
            tick;
            c_out_ready = 1'b0;
            total++;
            if (c_count !== 4'(c) || c_ae !== ae_tab[c] || c_af !== af_tab[c]) begin
                bad++;
                $display("FAIL flags_dn%0d count=%0d ae=%b af=%b exp %0d/%b/%b",
                         c, c_count, c_ae, c_af, c, ae_tab[c], af_tab[c]);
            end
        end
    endtask

    initial begin
        rst   = 1'b0;
        flush = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
        test_reset;
        test_reset_mid;
        test_fill_drain;
        test_wrap;
        test_back_to_back;
        test_flush;
        test_flags;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
